ram_arbiter: RTL



---
 rtl/ram_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter between two requesters for a paired-word RAM with a
// shared tri-state pair bus; one single-word read or write per 3 cycles.
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  output logic            a_ack,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  output logic            b_ack,
  output logic [DW-1:0]   rdata,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  inout  logic [2*DW-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic          gnt_sel;   // 0 = A, 1 = B
  logic          last_gnt;  // 0 = A, 1 = B
  logic [DW-1:0] wdata_q;
  logic          grant;
  logic          grant_b;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    // B wins only when A is idle or A was served last
    grant_b   = b_req && (!a_req || !last_gnt);
    unique case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      wdata_q  <= '0;
      gnt_sel  <= 1'b0;
      last_gnt <= 1'b1;
      rdata    <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
    end else begin
      state <= state_nxt;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      if (grant) begin
        gnt_sel  <= grant_b;
        ram_we   <= grant_b ? b_we    : a_we;
        ram_addr <= grant_b ? b_addr  : a_addr;
        wdata_q  <= grant_b ? b_wdata : a_wdata;
      end
      if (state == ACCESS) begin
        ram_we   <= 1'b0;
        last_gnt <= gnt_sel;
        a_ack    <= !gnt_sel;
        b_ack    <= gnt_sel;
        if (!ram_we)
          rdata <= ram_addr[0] ? ram_data[2*DW-1:DW] : ram_data[DW-1:0];
      end
    end
  end

  // Drive enable derives only from registers, so it never overlaps the RAM's read drive
  assign ram_data = (state == ACCESS && ram_we) ? {wdata_q, wdata_q} : 'z;

endmodule
